// File: rtl/io_buffer_sync_if.sv
// Pin-side bundle for io_buffer_sync: raw pin levels in, filtered levels and edge pulses out.
// Latency: none (pure wiring); all timing lives in io_buffer_sync.
// Backpressure: none; every signal is a level or single-cycle pulse.
interface io_buffer_sync_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;

    // Producer of pin levels, consumer of the filtered results
    modport master (
        output in,
        input  out,
        input  rise,
        input  fall,
        input  changed
    );

    // The buffer itself
    modport slave (
        input  in,
        output out,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/io_buffer_sync.sv
// Synchronises WIDTH async pins into clk, glitch-filters each bit, emits per-bit rise/fall pulses.
// Latency: SYNC_STAGES + FILTER_LEN edges to out/rise/fall, one more edge to changed.
// Backpressure: none; outputs are free-running registers.
module io_buffer_sync #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    io_buffer_sync_if.slave bus
);

    // Counter only needs to reach FILTER_LEN-1; keep at least one bit so FILTER_LEN=1 still elaborates.
    localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  out_q, out_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain per bit; no logic between stages so metastability has a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= bus.in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-bit filter: a new level must differ from out for FILTER_LEN consecutive cycles before it is
    // accepted; any return to the current level discards the partial count.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]  = '0;
                out_d[i]  = s[i];
                rise_d[i] = s[i];
                fall_d[i] = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // changed summarises the pulses already registered, so it trails them by one edge.
    assign changed_d = |(rise_q | fall_q);

    // Filter state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            out_q     <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_io_buffer_sync.sv
// Bench for io_buffer_sync: default 8-bit instance plus a WIDTH=1/SYNC=3/FILTER=1 instance.
// Expected outputs are queued per clock edge when stimulus is applied and checked at the falling edge.
// Inputs change only at falling edges so the next rising edge is "edge 1".
module tb_io_buffer_sync;

    logic clk;
    logic rst_n;
    int unsigned cyc;
    int n_chk;
    int n_err;

    io_buffer_sync_if #(.WIDTH(8)) bus8 ();
    io_buffer_sync_if #(.WIDTH(1)) bus1 ();

    io_buffer_sync #(
        .WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );

    io_buffer_sync #(
        .WIDTH(1), .SYNC_STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter: at a falling edge, cyc equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  out;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic        changed;
        string       name;
    } exp_t;

    typedef struct {
        logic [7:0] in_v;
        logic [7:0] exp_out;
        logic [7:0] exp_rise;
        logic [7:0] exp_fall;
    } vec_t;

    exp_t exp_q[$];
    exp_t exp1_q[$];
    exp_t mon_e;
    exp_t mon1_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push8(input int unsigned c, input logic [7:0] o, input logic [7:0] r,
                         input logic [7:0] f, input logic ch, input string nm);
        exp_t e;
        e.cyc = c; e.out = o; e.rise = r; e.fall = f; e.changed = ch; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic push1(input int unsigned c, input logic o, input logic r,
                         input logic f, input logic ch, input string nm);
        exp_t e;
        e.cyc = c; e.out = {7'd0, o}; e.rise = {7'd0, r}; e.fall = {7'd0, f};
        e.changed = ch; e.name = nm;
        exp1_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_out"},     bus8.out,     32'h0);
        chk({nm, "_rise"},    bus8.rise,    32'h0);
        chk({nm, "_fall"},    bus8.fall,    32'h0);
        chk({nm, "_changed"}, bus8.changed, 32'h0);
        chk({nm, "_out1"},    bus1.out,     32'h0);
    endtask

    // Scoreboard: compare every expectation scheduled for this edge; flag any that slipped past.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc < cyc) begin
                chk({mon_e.name, "_skipped"}, cyc, mon_e.cyc);
            end else begin
                chk({mon_e.name, "_out"},     bus8.out,     mon_e.out);
                chk({mon_e.name, "_rise"},    bus8.rise,    mon_e.rise);
                chk({mon_e.name, "_fall"},    bus8.fall,    mon_e.fall);
                chk({mon_e.name, "_changed"}, bus8.changed, mon_e.changed);
            end
        end
        while (exp1_q.size() > 0 && exp1_q[0].cyc <= cyc) begin
            mon1_e = exp1_q.pop_front();
            if (mon1_e.cyc < cyc) begin
                chk({mon1_e.name, "_skipped"}, cyc, mon1_e.cyc);
            end else begin
                chk({mon1_e.name, "_out"},     bus1.out,     mon1_e.out);
                chk({mon1_e.name, "_rise"},    bus1.rise,    mon1_e.rise);
                chk({mon1_e.name, "_fall"},    bus1.fall,    mon1_e.fall);
                chk({mon1_e.name, "_changed"}, bus1.changed, mon1_e.changed);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[7];
        int unsigned n;
        logic [7:0]  prev_out;
        logic        v, p1, p2;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'hFF};
        vecs[1] = '{8'h01, 8'h01, 8'h01, 8'h00};
        vecs[2] = '{8'h0F, 8'h0F, 8'h0E, 8'h00};
        vecs[3] = '{8'hF0, 8'hF0, 8'hF0, 8'h0F};
        vecs[4] = '{8'hA5, 8'hA5, 8'h05, 8'h50};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 8'hA5};
        vecs[6] = '{8'h00, 8'h00, 8'h00, 8'h00};

        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        bus8.in = 8'hFF;
        bus1.in = 1'b0;

        // Reset with all pins high: nothing may leak through while held.
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset_hold");
        @(negedge clk);
        n = cyc;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) push8(n + k, 8'h00, 8'h00, 8'h00, 1'b0, "reset_early");
        push8(n + 6, 8'hFF, 8'hFF, 8'h00, 1'b0, "reset_edge6");
        push8(n + 7, 8'hFF, 8'h00, 8'h00, 1'b1, "reset_edge7");
        push8(n + 8, 8'hFF, 8'h00, 8'h00, 1'b0, "reset_edge8");
        repeat (9) @(negedge clk);

        // Table: one step per vector, check edges 5, 6 and 7 after the change.
        prev_out = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            n = cyc;
            bus8.in = vecs[i].in_v;
            push8(n + 5, prev_out, 8'h00, 8'h00, 1'b0, $sformatf("vec%0d_e5", i));
            push8(n + 6, vecs[i].exp_out, vecs[i].exp_rise, vecs[i].exp_fall, 1'b0,
                  $sformatf("vec%0d_e6", i));
            push8(n + 7, vecs[i].exp_out, 8'h00, 8'h00,
                  (vecs[i].exp_rise | vecs[i].exp_fall) != 8'h00, $sformatf("vec%0d_e7", i));
            prev_out = vecs[i].exp_out;
            repeat (8) @(negedge clk);
        end

        // Glitch of 3 cycles on bit 3: must be discarded.
        n = cyc;
        bus8.in = 8'h08;
        for (int k = 1; k <= 10; k++) push8(n + k, 8'h00, 8'h00, 8'h00, 1'b0, "glitch3");
        repeat (3) @(negedge clk);
        bus8.in = 8'h00;
        repeat (9) @(negedge clk);

        // Pulse of exactly 4 cycles on bit 3: accepted, then removed.
        n = cyc;
        bus8.in = 8'h08;
        for (int k = 1; k <= 5; k++) push8(n + k, 8'h00, 8'h00, 8'h00, 1'b0, "pulse4_pre");
        push8(n + 6,  8'h08, 8'h08, 8'h00, 1'b0, "pulse4_rise");
        push8(n + 7,  8'h08, 8'h00, 8'h00, 1'b1, "pulse4_ch_r");
        push8(n + 8,  8'h08, 8'h00, 8'h00, 1'b0, "pulse4_hold");
        push8(n + 9,  8'h08, 8'h00, 8'h00, 1'b0, "pulse4_hold");
        push8(n + 10, 8'h00, 8'h00, 8'h08, 1'b0, "pulse4_fall");
        push8(n + 11, 8'h00, 8'h00, 8'h00, 1'b1, "pulse4_ch_f");
        repeat (4) @(negedge clk);
        bus8.in = 8'h00;
        repeat (10) @(negedge clk);

        // Establish out=F0 so an asynchronous reset is visible on out.
        n = cyc;
        bus8.in = 8'hF0;
        push8(n + 6, 8'hF0, 8'hF0, 8'h00, 1'b0, "pre_mid_rst");
        repeat (8) @(negedge clk);

        // Start a filter count on bit 1, reset two counts in, release with the pin still high.
        n = cyc;
        bus8.in = 8'hF2;
        for (int k = 1; k <= 3; k++) push8(n + k, 8'hF0, 8'h00, 8'h00, 1'b0, "mid_rst_pre");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_rst_async");
        repeat (2) @(negedge clk);
        #1 chk_all_zero("mid_rst_hold");
        @(negedge clk);
        n = cyc;
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) push8(n + k, 8'h00, 8'h00, 8'h00, 1'b0, "mid_rst_early");
        push8(n + 6, 8'hF2, 8'hF2, 8'h00, 1'b0, "mid_rst_edge6");
        push8(n + 7, 8'hF2, 8'h00, 8'h00, 1'b1, "mid_rst_edge7");
        repeat (8) @(negedge clk);

        // Narrow instance: toggle every 2 cycles; out follows 4 edges later with alternating pulses.
        p1 = 1'b0;
        p2 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            v = (((j >> 1) & 1) == 0);
            n = cyc;
            bus1.in = v;
            push1(n + 4, v, v & ~p1, ~v & p1, p1 != p2, $sformatf("sweep%0d", j));
            p2 = p1;
            p1 = v;
            @(negedge clk);
        end

        // Drain outstanding expectations within a bounded number of cycles.
        for (int k = 0; k < 50 && (exp_q.size() > 0 || exp1_q.size() > 0); k++) @(negedge clk);
        chk("drain_q8", exp_q.size(), 0);
        chk("drain_q1", exp1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
